// File: rtl/snake_sequencer.sv
// rtl/snake_sequencer.sv - idle-animation snake sequencer with integrated prescaler
module snake_sequencer #(
    parameter int REGLEN = 16,
    parameter int MAXSNK = 8,
    parameter int DIVW   = 8,
    parameter int LENW   = $clog2(MAXSNK + 1)
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic [DIVW-1:0]   div_lim,
    input  logic [LENW-1:0]   snk_len,
    input  logic [1:0]        mode,
    input  logic              run,
    input  logic              restart,
    output logic [REGLEN-1:0] out_reg,
    output logic              step,
    output logic              grown
);

    typedef enum logic {
        S_GROW = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] M_LEFT   = 2'b00;
    localparam logic [1:0] M_RIGHT  = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    state_t            state_q, state_d;
    logic [REGLEN-1:0] out_q, out_d;
    logic [DIVW-1:0]   cnt_q, cnt_d;
    logic [LENW-1:0]   gcnt_q, gcnt_d;
    logic [LENW-1:0]   len_q, len_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;

    logic              tick;
    logic              fill_right;
    logic [LENW-1:0]   len_clamp;
    logic [LENW-1:0]   gcnt_inc;
    logic [REGLEN-1:0] shl, shr;

    assign len_clamp = (snk_len > LENW'(MAXSNK)) ? LENW'(MAXSNK) : snk_len;
    assign gcnt_inc  = gcnt_q + LENW'(1);
    assign tick      = run && (cnt_q == div_lim);
    assign shl       = {out_q[REGLEN-2:0], 1'b0};
    assign shr       = {1'b0, out_q[REGLEN-1:1]};
    // Bounce always grows leftward; hold keeps growing on the side dir last pointed to.
    assign fill_right = (mode == M_RIGHT) || ((mode == M_HOLD) && dir_q);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (restart) begin
            len_d   = len_clamp;
            out_d   = '0;
            cnt_d   = '0;
            gcnt_d  = '0;
            dir_d   = 1'b0;
            state_d = (len_clamp == '0) ? S_RUN : S_GROW;
        end else begin
            if (run) begin
                cnt_d = tick ? '0 : cnt_q + DIVW'(1);
            end
            if (tick) begin
                step_d = 1'b1;
                if (mode == M_LEFT) begin
                    dir_d = 1'b0;
                end else if (mode == M_RIGHT) begin
                    dir_d = 1'b1;
                end
                if (state_q == S_GROW) begin
                    out_d  = fill_right ? {1'b1, out_q[REGLEN-1:1]} : {out_q[REGLEN-2:0], 1'b1};
                    gcnt_d = gcnt_inc;
                    if (gcnt_inc == len_q) begin
                        state_d = S_RUN;
                    end
                end else begin
                    case (mode)
                        M_LEFT:   out_d = {out_q[REGLEN-2:0], out_q[REGLEN-1]};
                        M_RIGHT:  out_d = {out_q[0], out_q[REGLEN-1:1]};
                        M_BOUNCE: begin
                            if (!dir_q) begin
                                out_d = shl;
                                if (shl[REGLEN-1]) begin
                                    dir_d = 1'b1;
                                end
                            end else begin
                                out_d = shr;
                                if (shr[0]) begin
                                    dir_d = 1'b0;
                                end
                            end
                        end
                        default:  step_d = 1'b0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            len_q   <= len_clamp;
            out_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            state_q <= (len_clamp == '0) ? S_RUN : S_GROW;
        end else begin
            len_q   <= len_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            state_q <= state_d;
        end
    end

    assign out_reg = out_q;
    assign step    = step_q;
    assign grown   = (state_q == S_RUN);

endmodule
